// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: two-source register-file write port arbiter with aging and optional read bypass (REGARB_BYPASS_EN)
module reg_write_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_rd,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_gnt,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_rd,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_gnt,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              regwrite,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0]     wait0_q, wait0_d;
  logic [ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              regwrite_q, regwrite_d;
  logic              force0;
  assign force0   = wait0_q == CW'(MAX_WAIT);
  assign req0_gnt = reset && req0_valid && (!req1_valid || force0);
  assign req1_gnt = reset && req1_valid && !req0_gnt;
  // next aging count and write command; writes to register 0 are consumed but never enabled
  always_comb begin
    wait0_d      = (req0_valid && !req0_gnt) ? (force0 ? wait0_q : wait0_q + 1'b1) : '0;
    write_reg_d  = req0_gnt ? req0_rd : req1_gnt ? req1_rd : write_reg_q;
    write_data_d = req0_gnt ? req0_data : req1_gnt ? req1_data : write_data_q;
    regwrite_d   = req0_gnt ? |req0_rd : req1_gnt ? |req1_rd : 1'b0;
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      wait0_q      <= '0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      regwrite_q   <= 1'b0;
    end else begin
      wait0_q      <= wait0_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      regwrite_q   <= regwrite_d;
    end
  end
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign regwrite   = regwrite_q;
`ifdef REGARB_BYPASS_EN
  assign rdata1 = (regwrite_q && write_reg_q != '0 && read_reg1 == write_reg_q) ? write_data_q : ReadData1;
  assign rdata2 = (regwrite_q && write_reg_q != '0 && read_reg2 == write_reg_q) ? write_data_q : ReadData2;
`else
  logic unused_read_idx;
  assign unused_read_idx = ^{read_reg1, read_reg2};
  assign rdata1 = ReadData1;
  assign rdata2 = ReadData2;
`endif
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed and held-request stimulus checked against a behavioural write-port model
module tb_reg_write_arbiter;
  localparam int MW = 3;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [4:0]  req0_rd = '0, req1_rd = '0;
  logic [63:0] req0_data = '0, req1_data = '0;
  logic        req0_gnt, req1_gnt;
  logic [4:0]  write_reg;
  logic [63:0] write_data;
  logic        regwrite;
  logic [4:0]  read_reg1 = '0, read_reg2 = '0;
  logic [63:0] ReadData1, ReadData2, rdata1, rdata2;
  int vectors = 0;
  int errs = 0;
  bit chk_on = 1'b0;
  logic [63:0] env_rf [32] = '{default: 64'h0};
  logic [63:0] mem_m [32] = '{default: 64'h0};
  int          m_lost = 0;
  logic        m_rw = 1'b0;
  logic [4:0]  m_wr = '0;
  logic [63:0] m_wd = '0;
  logic        g0, g1;
  logic [7:0]  pat;
  reg_write_arbiter #(.DATA_W(64), .ADDR_W(5), .MAX_WAIT(MW)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_gnt(req0_gnt),
    .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_gnt(req1_gnt),
    .write_reg(write_reg), .write_data(write_data), .regwrite(regwrite),
    .read_reg1(read_reg1), .read_reg2(read_reg2), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .rdata1(rdata1), .rdata2(rdata2)
  );
  always #5 clock = ~clock;
  assign ReadData1 = env_rf[read_reg1];
  assign ReadData2 = env_rf[read_reg2];
  // the bench plays the register file
  always @(posedge clock)
    if (regwrite && write_reg != 5'd0) env_rf[write_reg] <= write_data;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic exp_g0();
    return reset && req0_valid && (!req1_valid || m_lost >= MW);
  endfunction
  function automatic logic exp_g1();
    return reset && req1_valid && !exp_g0();
  endfunction
  function automatic logic [63:0] exp_rd(input logic [4:0] ra);
`ifdef REGARB_BYPASS_EN
    if (m_rw && m_wr != 5'd0 && m_wr == ra) return m_wd;
`endif
    return mem_m[ra];
  endfunction
  // model: lost-contest count, the command issued next cycle, and register contents
  always @(posedge clock) begin
    logic e0, e1;
    e0 = exp_g0();
    e1 = exp_g1();
    if (m_rw && m_wr != 5'd0) mem_m[m_wr] = m_wd;
    if (!reset) begin
      m_lost = 0; m_rw = 1'b0; m_wr = '0; m_wd = '0;
    end else begin
      m_lost = (req0_valid && !e0) ? m_lost + 1 : 0;
      if (e0) begin m_rw = req0_rd != 5'd0; m_wr = req0_rd; m_wd = req0_data; end
      else if (e1) begin m_rw = req1_rd != 5'd0; m_wr = req1_rd; m_wd = req1_data; end
      else m_rw = 1'b0;
    end
  end
  // per-cycle comparison against the model
  always @(negedge clock) if (chk_on) begin
    chk("gnt0", 64'(req0_gnt), 64'(exp_g0()));
    chk("gnt1", 64'(req1_gnt), 64'(exp_g1()));
    chk("regwrite", 64'(regwrite), 64'(m_rw));
    if (m_rw) begin
      chk("write_reg", 64'(write_reg), 64'(m_wr));
      chk("write_data", write_data, m_wd);
    end
    chk("rdata1", rdata1, exp_rd(read_reg1));
    chk("rdata2", rdata2, exp_rd(read_reg2));
  end
  task automatic cyc;
    @(posedge clock);
    #1;
  endtask
  initial begin
    req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 64'h33;
    req1_valid = 1'b1; req1_rd = 5'd4; req1_data = 64'h44;
    cyc();
    chk_on = 1'b1;
    @(negedge clock);
    chk("lit_rst_gnt0", 64'(req0_gnt), 64'd0);
    chk("lit_rst_gnt1", 64'(req1_gnt), 64'd0);
    chk("lit_rst_regwrite", 64'(regwrite), 64'd0);
    chk("lit_rst_write_reg", 64'(write_reg), 64'd0);
    chk("lit_rst_write_data", write_data, 64'd0);
    cyc();
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    cyc();
    req0_valid = 1'b1; req0_rd = 5'd2; req0_data = 64'h1000;
    @(negedge clock);
    chk("lit_single_gnt0", 64'(req0_gnt), 64'd1);
    cyc();
    req0_valid = 1'b0;
    @(negedge clock);
    chk("lit_single_regwrite", 64'(regwrite), 64'd1);
    chk("lit_single_write_reg", 64'(write_reg), 64'd2);
    chk("lit_single_write_data", write_data, 64'h1000);
    cyc();
    read_reg1 = 5'd2;
    @(negedge clock);
    chk("lit_single_rdata1", rdata1, 64'h1000);
    cyc();
    pat = 8'b0111_0111;
    req0_valid = 1'b1; req0_rd = 5'd10; req0_data = 64'hA0;
    req1_valid = 1'b1; req1_rd = 5'd11; req1_data = 64'hB0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      g1 = req1_gnt;
      chk($sformatf("lit_aging_gnt1_%0d", i), 64'(g1), 64'(pat[i]));
      cyc();
      if (g1) begin req1_rd = 5'(11 + i); req1_data = 64'hB1 + 64'(i); end
      else begin req0_rd = 5'(10 + i); req0_data = 64'hA1 + 64'(i); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc();
    req0_valid = 1'b1; req0_rd = 5'd0; req0_data = 64'hFFFF_FFFF; read_reg1 = 5'd0;
    @(negedge clock);
    chk("lit_zero_gnt0", 64'(req0_gnt), 64'd1);
    cyc();
    req0_valid = 1'b0;
    @(negedge clock);
    chk("lit_zero_regwrite", 64'(regwrite), 64'd0);
    cyc();
    @(negedge clock);
    chk("lit_zero_rdata1", rdata1, 64'd0);
    cyc();
    req1_valid = 1'b1; req1_rd = 5'd5; req1_data = 64'hABCD;
    @(negedge clock);
    chk("lit_byp_gnt1", 64'(req1_gnt), 64'd1);
    cyc();
    req1_valid = 1'b0; read_reg1 = 5'd5; read_reg2 = 5'd5;
    @(negedge clock);
`ifdef REGARB_BYPASS_EN
    chk("lit_byp_rdata1", rdata1, 64'hABCD);
    chk("lit_byp_rdata2", rdata2, 64'hABCD);
`else
    chk("lit_byp_rdata1", rdata1, 64'd0);
    chk("lit_byp_rdata2", rdata2, 64'd0);
`endif
    cyc();
    @(negedge clock);
    chk("lit_byp_rdata1_late", rdata1, 64'hABCD);
    cyc();
    reset = 1'b0; req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 64'h77;
    @(negedge clock);
    chk("lit_rstmid_gnt0", 64'(req0_gnt), 64'd0);
    cyc();
    reset = 1'b1;
    @(negedge clock);
    chk("lit_rstmid_regwrite", 64'(regwrite), 64'd0);
    chk("lit_rstmid_gnt0_after", 64'(req0_gnt), 64'd1);
    cyc();
    req0_valid = 1'b0;
    @(negedge clock);
    chk("lit_rstmid_write_reg", 64'(write_reg), 64'd7);
    chk("lit_rstmid_regwrite_on", 64'(regwrite), 64'd1);
    cyc();
    @(negedge clock);
    chk("lit_rstmid_once", 64'(regwrite), 64'd0);
    cyc();
    req0_valid = 1'b1; req0_rd = 5'd9; req0_data = 64'hAAAA;
    req1_valid = 1'b1; req1_rd = 5'd9; req1_data = 64'hBBBB;
    @(negedge clock);
    chk("lit_same_gnt1", 64'(req1_gnt), 64'd1);
    cyc();
    req1_valid = 1'b0;
    cyc();
    req0_valid = 1'b0;
    cyc();
    read_reg1 = 5'd9;
    @(negedge clock);
    chk("lit_same_last_writer", rdata1, 64'hAAAA);
    cyc();
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      g0 = req0_gnt;
      g1 = req1_gnt;
      cyc();
      reset = $urandom_range(0, 19) != 0;
      if (!req0_valid || g0) begin
        req0_valid = 1'($urandom_range(0, 1));
        req0_rd = 5'($urandom_range(0, 7));
        req0_data = {$urandom, $urandom};
      end
      if (!req1_valid || g1) begin
        req1_valid = 1'($urandom_range(0, 1));
        req1_rd = 5'($urandom_range(0, 7));
        req1_data = {$urandom, $urandom};
      end
      read_reg1 = 5'($urandom_range(0, 7));
      read_reg2 = 5'($urandom_range(0, 7));
    end
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    cyc();
    cyc();
    @(negedge clock);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
